// File: rtl/resq_multi_queue.sv
// Multi-channel emergency request queue: one evacuation FIFO plus priority channels with age boost.
// Optional build macro RESQ_DUP_MERGE_EN merges same-zone inserts into an existing entry of the channel.
module resq_multi_queue #(
  parameter int NUM_RES   = 3,
  parameter int DEPTH     = 4,
  parameter int ZONE_W    = 8,
  parameter int PRIO_W    = 2,
  parameter int AGE_LIMIT = 3
) (
  input  logic                       Clock,
  input  logic                       Reset_Queue_n,
  input  logic                       Insert,
  input  logic                       Serve,
  input  logic [ZONE_W-1:0]          Zone,
  input  logic [PRIO_W-1:0]          Priority,
  input  logic [$clog2(NUM_RES)-1:0] Resource_line,
  output logic                       Out_Valid,
  output logic [ZONE_W-1:0]          Output_Zone,
  output logic [PRIO_W-1:0]          Output_Priority,
  output logic [$clog2(NUM_RES)-1:0] Output_Resource,
  output logic                       Output_Boost,
  output logic [NUM_RES-1:0]         Full,
  output logic [NUM_RES-1:0]         Empty,
  output logic                       Insert_Drop
);

  localparam int RW  = $clog2(NUM_RES);
  localparam int NP  = NUM_RES - 1;
  localparam int PCW = (NP > 1) ? $clog2(NP) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);
  localparam int AW  = 4;
  localparam int KW  = PRIO_W + 1;

  logic [NP-1:0][DEPTH-1:0]             pq_valid_q, pq_valid_d;
  logic [NP-1:0][DEPTH-1:0][ZONE_W-1:0] pq_zone_q,  pq_zone_d;
  logic [NP-1:0][DEPTH-1:0][PRIO_W-1:0] pq_prio_q,  pq_prio_d;
  logic [NP-1:0][DEPTH-1:0][AW-1:0]     pq_age_q,   pq_age_d;
  logic [NP-1:0][DEPTH-1:0]             pq_boost_q, pq_boost_d;
  logic [DEPTH-1:0][ZONE_W-1:0]         fifo_zone_q, fifo_zone_d;
  logic [PW-1:0]                        rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]                        wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]                        count_q, count_d;
  logic                                 drop_q, drop_d;

  logic           sel_valid_s, sel_fifo_s, cand_s;
  logic [PCW-1:0] sel_pc_s;
  logic [PW-1:0]  sel_slot_s;
  logic [KW-1:0]  best_key_s;
  logic           serve_exec_s, res_ok_s, is_evac_s, fifo_hit_s, tgt_full_s;
  logic           merge_hit_s, ins_ok_s, push_s, pop_s, done_s;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Pick the request to present: FIFO head first, else highest {boost, prio}, lowest channel/slot on ties
  always_comb begin
    sel_valid_s = 1'b0;
    sel_fifo_s  = 1'b0;
    sel_pc_s    = '0;
    sel_slot_s  = '0;
    best_key_s  = '0;
    cand_s      = 1'b0;
    if (count_q != '0) begin
      sel_valid_s = 1'b1;
      sel_fifo_s  = 1'b1;
    end else begin
      for (int c = 0; c < NP; c++) begin
        for (int s = 0; s < DEPTH; s++) begin
          cand_s = pq_valid_q[c][s] &&
                   (!sel_valid_s || ({pq_boost_q[c][s], pq_prio_q[c][s]} > best_key_s));
          if (cand_s) begin
            sel_valid_s = 1'b1;
            sel_pc_s    = PCW'(c);
            sel_slot_s  = PW'(s);
            best_key_s  = {pq_boost_q[c][s], pq_prio_q[c][s]};
          end else begin
            best_key_s  = best_key_s;
          end
        end
      end
    end
  end

  // Drive the presentation port and per-channel status from registered state
  always_comb begin
    Out_Valid       = sel_valid_s;
    Output_Zone     = '0;
    Output_Priority = '0;
    Output_Resource = '0;
    Output_Boost    = 1'b0;
    if (sel_valid_s && sel_fifo_s) begin
      Output_Zone     = fifo_zone_q[rd_ptr_q];
      Output_Resource = RW'(NP);
    end else if (sel_valid_s) begin
      Output_Zone     = pq_zone_q[sel_pc_s][sel_slot_s];
      Output_Priority = pq_prio_q[sel_pc_s][sel_slot_s];
      Output_Resource = RW'(sel_pc_s);
      Output_Boost    = pq_boost_q[sel_pc_s][sel_slot_s];
    end else begin
      Out_Valid       = 1'b0;
    end
    for (int c = 0; c < NP; c++) begin
      Full[c]  = &pq_valid_q[c];
      Empty[c] = ~|pq_valid_q[c];
    end
    Full[NP]    = (count_q == CW'(DEPTH));
    Empty[NP]   = (count_q == '0);
    Insert_Drop = drop_q;
  end

  // Next-state: serve and aging, evac cancellation, then insert (all decisions use pre-edge state)
  always_comb begin
    pq_valid_d  = pq_valid_q;
    pq_zone_d   = pq_zone_q;
    pq_prio_d   = pq_prio_q;
    pq_age_d    = pq_age_q;
    pq_boost_d  = pq_boost_q;
    fifo_zone_d = fifo_zone_q;
    rd_ptr_d    = rd_ptr_q;
    wr_ptr_d    = wr_ptr_q;
    fifo_hit_s  = 1'b0;
    tgt_full_s  = 1'b0;
    merge_hit_s = 1'b0;
    done_s      = 1'b0;

    for (int j = 0; j < DEPTH; j++) begin
      fifo_hit_s = fifo_hit_s | ((fifo_zone_q[j] == Zone) &&
        (((j >= int'(rd_ptr_q)) ? (j - int'(rd_ptr_q)) : (j - int'(rd_ptr_q) + DEPTH))
         < int'(count_q)));
    end

    res_ok_s     = ({1'b0, Resource_line} < (RW + 1)'(NUM_RES));
    is_evac_s    = (Resource_line == RW'(NP));
    serve_exec_s = Serve && sel_valid_s;
    pop_s        = serve_exec_s && sel_fifo_s;

    if (is_evac_s) begin
      tgt_full_s = (count_q == CW'(DEPTH));
    end else begin
      for (int c = 0; c < NP; c++) begin
        if (int'(Resource_line) == c) begin
          tgt_full_s = &pq_valid_q[c];
`ifdef RESQ_DUP_MERGE_EN
          for (int s = 0; s < DEPTH; s++) begin
            merge_hit_s = merge_hit_s | (pq_valid_q[c][s] && (pq_zone_q[c][s] == Zone));
          end
`else
          merge_hit_s = 1'b0;
`endif
        end else begin
          tgt_full_s = tgt_full_s;
        end
      end
    end

    ins_ok_s = Insert && res_ok_s && (is_evac_s || !fifo_hit_s) && (!tgt_full_s || merge_hit_s);
    drop_d   = Insert && !ins_ok_s;
    push_s   = ins_ok_s && is_evac_s;

    for (int c = 0; c < NP; c++) begin
      for (int s = 0; s < DEPTH; s++) begin
        if (serve_exec_s && !sel_fifo_s && (sel_pc_s == PCW'(c)) && (sel_slot_s == PW'(s))) begin
          pq_valid_d[c][s] = 1'b0;
          pq_age_d[c][s]   = '0;
          pq_boost_d[c][s] = 1'b0;
        end else if (serve_exec_s && pq_valid_q[c][s] && (pq_age_q[c][s] < AW'(AGE_LIMIT))) begin
          pq_age_d[c][s]   = pq_age_q[c][s] + AW'(1);
          pq_boost_d[c][s] = (pq_age_q[c][s] == AW'(AGE_LIMIT - 1));
        end else begin
          pq_age_d[c][s]   = pq_age_q[c][s];
        end
        // Evac insert clears same-zone requests even when the evac entry itself is dropped
        if (Insert && res_ok_s && is_evac_s && pq_valid_q[c][s] && (pq_zone_q[c][s] == Zone)) begin
          pq_valid_d[c][s] = 1'b0;
          pq_age_d[c][s]   = '0;
          pq_boost_d[c][s] = 1'b0;
        end else begin
          pq_valid_d[c][s] = pq_valid_d[c][s];
        end
      end
    end

    if (pop_s) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    if (push_s) begin
      fifo_zone_d[wr_ptr_q] = Zone;
      wr_ptr_d              = ptr_inc(wr_ptr_q);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    count_d = count_q + CW'(push_s) - CW'(pop_s);

    for (int c = 0; c < NP; c++) begin
      if (ins_ok_s && !is_evac_s && (int'(Resource_line) == c)) begin
        for (int s = 0; s < DEPTH; s++) begin
          if (!done_s && merge_hit_s && pq_valid_q[c][s] && (pq_zone_q[c][s] == Zone)) begin
            pq_prio_d[c][s] = (Priority > pq_prio_q[c][s]) ? Priority : pq_prio_q[c][s];
            done_s          = 1'b1;
          end else if (!done_s && !merge_hit_s && !pq_valid_q[c][s]) begin
            pq_valid_d[c][s] = 1'b1;
            pq_zone_d[c][s]  = Zone;
            pq_prio_d[c][s]  = Priority;
            pq_age_d[c][s]   = '0;
            pq_boost_d[c][s] = 1'b0;
            done_s           = 1'b1;
          end else begin
            done_s = done_s;
          end
        end
      end else begin
        done_s = 1'b0;
      end
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge Clock) begin
    if (!Reset_Queue_n) begin
      pq_valid_q  <= '0;
      pq_zone_q   <= '0;
      pq_prio_q   <= '0;
      pq_age_q    <= '0;
      pq_boost_q  <= '0;
      fifo_zone_q <= '0;
      rd_ptr_q    <= '0;
      wr_ptr_q    <= '0;
      count_q     <= '0;
      drop_q      <= 1'b0;
    end else begin
      pq_valid_q  <= pq_valid_d;
      pq_zone_q   <= pq_zone_d;
      pq_prio_q   <= pq_prio_d;
      pq_age_q    <= pq_age_d;
      pq_boost_q  <= pq_boost_d;
      fifo_zone_q <= fifo_zone_d;
      rd_ptr_q    <= rd_ptr_d;
      wr_ptr_q    <= wr_ptr_d;
      count_q     <= count_d;
      drop_q      <= drop_d;
    end
  end

endmodule
